// File: rtl/sv_cmp_pkg.sv
// Shared types and elaboration helpers for the chunked serial comparator.
package sv_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int calc_nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  function automatic int calc_idxw(input int nchunk);
    return (nchunk <= 1) ? 1 : $clog2(nchunk);
  endfunction

  function automatic bit chunking_ok(input int width, input int chunk);
    return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/chunk_cmp.sv
// Narrow unsigned comparator; flip_msb biases both operands so a signed chunk
// can be ordered with the same unsigned compare.
module chunk_cmp #(
  parameter int CHUNK = 16
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             flip_msb,
  output logic             gt,
  output logic             eq
);

  logic [CHUNK-1:0] x_f;
  logic [CHUNK-1:0] y_f;

  always_comb begin
    x_f = x;
    y_f = y;
    x_f[CHUNK-1] = x[CHUNK-1] ^ flip_msb;
    y_f[CHUNK-1] = y[CHUNK-1] ^ flip_msb;
  end

  assign gt = (x_f > y_f);
  assign eq = (x_f == y_f);

endmodule

// File: rtl/serial_gte_ctrl.sv
// Evaluates a >= b on wide operands one CHUNK at a time, MSB chunk first,
// stopping at the first chunk that differs.
module serial_gte_ctrl
  import sv_cmp_pkg::*;
#(
  parameter  int WIDTH  = 128,
  parameter  int CHUNK  = 16,
  localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK),
  localparam int IDXW   = calc_idxw(NCHUNK)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             gte,
  output logic             eq,
  output logic [IDXW:0]    chunks_used
);

  if (!chunking_ok(WIDTH, CHUNK)) begin : g_bad_chunking
    $error("serial_gte_ctrl: WIDTH must be a non-zero multiple of CHUNK");
  end

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; the producer holds valid and payload until then, and the
  // result payload stays stable while out_valid is high.

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               signed_q, signed_d;
  logic [IDXW-1:0]    idx_q, idx_d;
  logic [IDXW:0]      count_q, count_d;
  logic               out_valid_q, out_valid_d;
  logic               gte_q, gte_d;
  logic               eq_q, eq_d;
  logic [IDXW:0]      used_q, used_d;

  logic [WIDTH-1:0]   a_sh, b_sh;
  logic [CHUNK-1:0]   a_chunk, b_chunk;
  logic               flip_msb;
  logic               c_gt, c_eq;

  assign a_sh     = a_q >> (int'(idx_q) * CHUNK);
  assign b_sh     = b_q >> (int'(idx_q) * CHUNK);
  assign a_chunk  = a_sh[CHUNK-1:0];
  assign b_chunk  = b_sh[CHUNK-1:0];
  // Only the top chunk carries the sign bit.
  assign flip_msb = signed_q && (idx_q == IDXW'(NCHUNK - 1));

  chunk_cmp #(.CHUNK(CHUNK)) u_chunk_cmp (
    .x        (a_chunk),
    .y        (b_chunk),
    .flip_msb (flip_msb),
    .gt       (c_gt),
    .eq       (c_eq)
  );

  assign in_ready    = (state_q == IDLE) && !rst;
  assign out_valid   = out_valid_q;
  assign gte         = gte_q;
  assign eq          = eq_q;
  assign chunks_used = used_q;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    signed_d    = signed_q;
    idx_d       = idx_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    gte_d       = gte_q;
    eq_d        = eq_q;
    used_d      = used_q;
    unique case (state_q)
      IDLE: begin
        out_valid_d = 1'b0;
        if (in_valid && in_ready) begin
          a_d      = a;
          b_d      = b;
          signed_d = is_signed;
          idx_d    = IDXW'(NCHUNK - 1);
          count_d  = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        count_d = count_q + 1'b1;
        if (!c_eq) begin
          gte_d       = c_gt;
          eq_d        = 1'b0;
          used_d      = count_q + 1'b1;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else if (idx_q == '0) begin
          gte_d       = 1'b1;
          eq_d        = 1'b1;
          used_d      = count_q + 1'b1;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      signed_q    <= 1'b0;
      idx_q       <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      gte_q       <= 1'b0;
      eq_q        <= 1'b0;
      used_q      <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      signed_q    <= signed_d;
      idx_q       <= idx_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      gte_q       <= gte_d;
      eq_q        <= eq_d;
      used_q      <= used_d;
    end
  end

endmodule

// File: tb/tb_serial_gte_ctrl.sv
// Bench for serial_gte_ctrl at WIDTH=128, CHUNK=16: directed cases, random
// operands against a whole-word reference model, backpressure and mid-run reset.
module tb_serial_gte_ctrl;

  localparam int WIDTH  = 128;
  localparam int CHUNK  = 16;
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int LIMIT  = 40;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             is_signed;
  logic             out_valid;
  logic             out_ready;
  logic             gte;
  logic             eq;
  logic [3:0]       chunks_used;

  int total = 0;
  int bad   = 0;

  serial_gte_ctrl #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .is_signed   (is_signed),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .gte         (gte),
    .eq          (eq),
    .chunks_used (chunks_used)
  );

  always #5 clk = ~clk;

  // Reference: whole-word compare; chunks examined run from the top down to
  // the highest chunk holding a differing bit.
  function automatic void model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                input logic ms, output logic m_gte, output logic m_eq,
                                output int m_used);
    logic [WIDTH-1:0] diff;
    int hi;
    m_gte = ms ? ($signed(ma) >= $signed(mb)) : (ma >= mb);
    m_eq  = (ma == mb);
    diff  = ma ^ mb;
    hi    = -1;
    for (int i = 0; i < WIDTH; i++) if (diff[i]) hi = i;
    m_used = (hi < 0) ? NCHUNK : NCHUNK - (hi / CHUNK);
  endfunction

  task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb, input logic ts);
    @(negedge clk);
    a = ta; b = tb; is_signed = ts; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < LIMIT) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_one(input string name, input logic [WIDTH-1:0] ta,
                         input logic [WIDTH-1:0] tb, input logic ts);
    logic e_gte, e_eq;
    int e_used, lat;
    model(ta, tb, ts, e_gte, e_eq, e_used);
    send(ta, tb, ts);
    wait_out(lat);
    total++;
    if (lat !== e_used) begin
      bad++; $display("FAIL %s latency: got %0d want %0d", name, lat, e_used);
    end
    total++;
    if (gte !== e_gte || eq !== e_eq || chunks_used !== 4'(e_used)) begin
      bad++;
      $display("FAIL %s result: gte=%b eq=%b used=%0d want gte=%b eq=%b used=%0d",
               name, gte, eq, chunks_used, e_gte, e_eq, e_used);
    end
    ack();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL %s release: out_valid=%b in_ready=%b want 0 1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; is_signed = 1'b0;
    #3;
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || gte !== 1'b0 || eq !== 1'b0 || chunks_used !== 4'd0) begin
      bad++;
      $display("FAIL reset_values: in_ready=%b out_valid=%b gte=%b eq=%b used=%0d want all 0",
               in_ready, out_valid, gte, eq, chunks_used);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_release: in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [WIDTH-1:0] ones, pat, min_s, max_s;
    ones  = '1;
    pat   = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
    min_s = {1'b1, {(WIDTH-1){1'b0}}};
    max_s = {1'b0, {(WIDTH-1){1'b1}}};
    run_one("u_5_3",        128'd5, 128'd3, 1'b0);
    run_one("s_ones_0",     ones,   '0,     1'b1);
    run_one("u_ones_0",     ones,   '0,     1'b0);
    run_one("s_equal",      pat,    pat,    1'b1);
    run_one("s_min_max",    min_s,  max_s,  1'b1);
    run_one("u_min_max",    min_s,  max_s,  1'b0);
    run_one("u_equal_zero", '0,     '0,     1'b0);
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] ra, rb;
    int keep;
    for (int n = 0; n < 40; n++) begin
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      keep = $urandom_range(0, NCHUNK);
      // Share the top 'keep' chunks so early exit lands on every depth.
      for (int c = NCHUNK - 1; c >= NCHUNK - keep; c--)
        rb[c*CHUNK +: CHUNK] = ra[c*CHUNK +: CHUNK];
      if ($urandom_range(0, 3) == 0) rb[0] = ~rb[0];
      run_one("random", ra, rb, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_backpressure();
    logic e_gte, e_eq;
    int e_used, lat;
    logic [WIDTH-1:0] oa, ob;
    oa = 128'h8000_0000_0000_0000_0000_0000_0000_0001;
    ob = 128'h0000_0000_0000_0000_0000_0000_0000_0002;
    model(oa, ob, 1'b1, e_gte, e_eq, e_used);
    send(oa, ob, 1'b1);
    wait_out(lat);
    for (int s = 0; s < 3; s++) begin
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || gte !== e_gte || eq !== e_eq || chunks_used !== 4'(e_used)) begin
        bad++;
        $display("FAIL stall_hold: ov=%b ir=%b gte=%b eq=%b used=%0d want 1 0 %b %b %0d",
                 out_valid, in_ready, gte, eq, chunks_used, e_gte, e_eq, e_used);
      end
      a = '1; b = '0; is_signed = 1'b0; in_valid = (s == 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || gte !== e_gte || chunks_used !== 4'(e_used)) begin
      bad++; $display("FAIL stall_end: ov=%b gte=%b used=%0d want 1 %b %0d", out_valid, gte, chunks_used, e_gte, e_used);
    end
    ack();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL stall_release: ov=%b ir=%b want 0 1", out_valid, in_ready);
    end
    run_one("after_stall", 128'd7, 128'd7 << 64, 1'b0);
  endtask

  task automatic test_reset_mid();
    int lat;
    send(128'd5, 128'd3, 1'b0);
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      bad++; $display("FAIL mid_reset: ov=%b ir=%b want 0 0", out_valid, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || chunks_used !== 4'd0) begin
      bad++; $display("FAIL mid_reset_release: ir=%b ov=%b used=%0d want 1 0 0", in_ready, out_valid, chunks_used);
    end
    wait_out(lat);
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL mid_reset_discard: stale result appeared after %0d cycles", lat);
    end
    run_one("post_reset_2_9", 128'd2, 128'd9, 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
